// File: rtl/wb_initiator.sv
// -----------------------------------------------------------------------------
// wb_initiator
//
// Single-outstanding Wishbone B4 pipelined initiator. Each command accepted on
// the req_* valid/ready stream becomes exactly one Wishbone bus cycle. When
// the cycle ends, a status/data response is presented on rsp_*.
//
// Optional feature macro: WB_INITIATOR_TIMEOUT_EN
//   When defined, a 16-bit watchdog aborts a bus cycle that has not terminated
//   within TIMEOUT_CYCLES clocks and reports status 2'b10.
//   When undefined, the block waits indefinitely for a termination.
//
// Parameters
//   ADDR_WIDTH     : width of req_adr_i / wb_adr_o
//   MAX_RETRY      : re-issues allowed after wb_rty_i (0..15)
//   TIMEOUT_CYCLES : watchdog limit in clocks (1..65535), macro builds only
//
// Ports
//   clk_i, rst_n_i              : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   : command handshake
//   req_we_i, req_adr_i,
//   req_dat_i, req_sel_i        : command fields (write flag, address, data, selects)
//   rsp_valid_o / rsp_ready_i   : response handshake
//   rsp_dat_o, rsp_status_o     : read data (0 for writes / failures), status
//                                 00 ok, 01 err, 10 timeout, 11 retry exhausted
//   wb_cyc_o, wb_stb_o, wb_we_o,
//   wb_adr_o, wb_sel_o, wb_dat_o: Wishbone initiator outputs (all registered)
//   wb_ack_i, wb_err_i, wb_rty_i,
//   wb_stall_i, wb_dat_i        : Wishbone responder inputs
// -----------------------------------------------------------------------------
module wb_initiator #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MAX_RETRY      = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_adr_i,
  input  logic [31:0]           req_dat_i,
  input  logic [3:0]            req_sel_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_dat_o,
  output logic [1:0]            rsp_status_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [3:0]            wb_sel_o,
  output logic [31:0]           wb_dat_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i,
  input  logic                  wb_rty_i,
  input  logic                  wb_stall_i,
  input  logic [31:0]           wb_dat_i
);

  // Reject out-of-range parameter values at elaboration; no hardware results.
  if (MAX_RETRY < 0 || MAX_RETRY > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("wb_initiator: MAX_RETRY or TIMEOUT_CYCLES out of range");
  end

  localparam logic [3:0] MAX_RETRY_L = 4'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

  state_t     state_reg;
  logic [3:0] retry_reg;

  // A termination only counts once the strobe has been accepted (ADDR with
  // no stall) or while waiting for the response (WAIT).
  logic live;
  logic term_any;
  logic retry_ok;

  always_comb begin
    live     = ((state_reg == ADDR) && !wb_stall_i) || (state_reg == WAIT);
    term_any = live && (wb_err_i || wb_rty_i || wb_ack_i);
    retry_ok = (retry_reg < MAX_RETRY_L);
  end

`ifdef WB_INITIATOR_TIMEOUT_EN
  logic [15:0] wd_reg;
  logic [15:0] wd_next;
  logic        wd_expired;

  always_comb begin
    wd_next    = wd_reg + 16'd1;
    wd_expired = (wd_next == 16'(TIMEOUT_CYCLES));
  end
`endif

  assign req_ready_o = (state_reg == IDLE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= IDLE;
      retry_reg    <= 4'd0;
      wb_cyc_o     <= 1'b0;
      wb_stb_o     <= 1'b0;
      wb_we_o      <= 1'b0;
      wb_adr_o     <= '0;
      wb_sel_o     <= 4'd0;
      wb_dat_o     <= 32'd0;
      rsp_valid_o  <= 1'b0;
      rsp_dat_o    <= 32'd0;
      rsp_status_o <= 2'b00;
`ifdef WB_INITIATOR_TIMEOUT_EN
      wd_reg       <= 16'd0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            wb_we_o   <= req_we_i;
            wb_adr_o  <= req_adr_i;
            wb_dat_o  <= req_dat_i;
            wb_sel_o  <= req_sel_i;
            retry_reg <= 4'd0;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            state_reg <= ADDR;
`ifdef WB_INITIATOR_TIMEOUT_EN
            wd_reg    <= 16'd0;
`endif
          end
        end

        ADDR, WAIT: begin
`ifdef WB_INITIATOR_TIMEOUT_EN
          // Counts through retries; only a fresh command clears it.
          wd_reg <= wd_next;
`endif
          if (term_any) begin
            if (wb_err_i) begin
              wb_cyc_o     <= 1'b0;
              wb_stb_o     <= 1'b0;
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= 2'b01;
              rsp_dat_o    <= 32'd0;
              state_reg    <= RESP;
            end else if (wb_rty_i) begin
              if (retry_ok) begin
                // Keep the cycle open and re-present the strobe.
                retry_reg <= retry_reg + 4'd1;
                wb_stb_o  <= 1'b1;
                state_reg <= ADDR;
              end else begin
                wb_cyc_o     <= 1'b0;
                wb_stb_o     <= 1'b0;
                rsp_valid_o  <= 1'b1;
                rsp_status_o <= 2'b11;
                rsp_dat_o    <= 32'd0;
                state_reg    <= RESP;
              end
            end else begin
              wb_cyc_o     <= 1'b0;
              wb_stb_o     <= 1'b0;
              rsp_valid_o  <= 1'b1;
              rsp_status_o <= 2'b00;
              rsp_dat_o    <= wb_we_o ? 32'd0 : wb_dat_i;
              state_reg    <= RESP;
            end
`ifdef WB_INITIATOR_TIMEOUT_EN
          end else if (wd_expired) begin
            wb_cyc_o     <= 1'b0;
            wb_stb_o     <= 1'b0;
            rsp_valid_o  <= 1'b1;
            rsp_status_o <= 2'b10;
            rsp_dat_o    <= 32'd0;
            state_reg    <= RESP;
`endif
          end else if (live) begin
            // Strobe accepted without termination: wait for the response.
            wb_stb_o  <= 1'b0;
            state_reg <= WAIT;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state_reg   <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
